sel_mux_pipe: RTL and testbench



---
 rtl/sel_mux_pipe.sv | 98 +++++++++
 tb/tb_sel_mux_pipe.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sel_mux_pipe.sv
// Registered N-way word selector with a valid/ready handshake and a 2-entry
// (output register + skid) buffer, sticky bad-select flag and transfer counter.
module sel_mux_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err,
    input  logic                    err_clr,
    output logic [CNT_W-1:0]        xfer_cnt
);

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_skid_full;
    logic             r_sel_err;
    logic [CNT_W-1:0] r_xfer_cnt;

    logic [WIDTH-1:0] w_word;
    logic             w_oor;
    logic             w_accept;
    logic             w_emit;

    // Out-of-range selects fall back to slice 0 and raise w_oor.
    always_comb begin
        w_word = in_data[WIDTH-1:0];
        w_oor  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                w_word = in_data[k*WIDTH +: WIDTH];
                w_oor  = 1'b0;
            end
        end
    end

    // in_ready depends only on the skid register, never on out_ready.
    assign in_ready = ~r_skid_full;
    assign w_accept = in_valid & ~r_skid_full;
    assign w_emit   = r_out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_skid_data <= '0;
            r_skid_full <= 1'b0;
        end else if (r_skid_full) begin
            if (w_emit) begin
                r_out_data  <= r_skid_data;
                r_skid_full <= 1'b0;
            end
        end else if (!r_out_valid || w_emit) begin
            if (w_accept) begin
                r_out_data  <= w_word;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_data <= w_word;
            r_skid_full <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_err  <= 1'b0;
            r_xfer_cnt <= '0;
        end else begin
            // A new bad select takes priority over a simultaneous clear.
            if (w_accept && w_oor) begin
                r_sel_err <= 1'b1;
            end else if (err_clr) begin
                r_sel_err <= 1'b0;
            end
            if (w_emit) begin
                r_xfer_cnt <= r_xfer_cnt + 1'b1;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign sel_err   = r_sel_err;
    assign xfer_cnt  = r_xfer_cnt;

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Randomised scoreboard bench for sel_mux_pipe: the driver issues traffic, a
// negedge monitor keeps an in-flight word queue as the reference and compares.
module tb_sel_mux_pipe;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 3;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sel_err;
    logic                    err_clr;
    logic [CNT_W-1:0]        xfer_cnt;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_q[$];
    int               m_cnt = 0;
    logic             m_err = 1'b0;
    logic             acc;
    logic             emt;
    logic [WIDTH-1:0] slc;

    sel_mux_pipe #(
        .WIDTH (WIDTH),
        .NUM_IN(NUM_IN),
        .SEL_W (SEL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .sel      (sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sel_err  (sel_err),
        .err_clr  (err_clr),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic put(input logic v, input logic [1:0] s, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c,
                       input logic ordy, input logic clr);
        @(posedge clk);
        #1;
        in_valid  = v;
        sel       = s;
        in_data   = {c, b, a};
        out_ready = ordy;
        err_clr   = clr;
    endtask

    // Reference: queue of accepted-but-not-emitted words; occupancy alone
    // determines out_valid (>0) and in_ready (<2).
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_cnt = 0;
            m_err = 1'b0;
        end else begin
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
            if (exp_q.size() > 0) chk("out_data", out_data, exp_q[0]);
            chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
            chk("sel_err", 32'(sel_err), 32'(m_err));
            acc = in_valid && (exp_q.size() < 2);
            emt = out_ready && (exp_q.size() > 0);
            if (emt) begin
                void'(exp_q.pop_front());
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end
            if (acc) begin
                slc = (int'(sel) < NUM_IN) ? in_data[int'(sel)*WIDTH +: WIDTH] : in_data[WIDTH-1:0];
                exp_q.push_back(slc);
            end
            if (acc && int'(sel) >= NUM_IN) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end
    end

    localparam logic [31:0] A = 32'h1111_1111;
    localparam logic [31:0] B = 32'h2222_2222;
    localparam logic [31:0] C = 32'h3333_3333;

    initial begin
        rst = 1'b1; in_valid = 1'b0; sel = '0; in_data = '0; out_ready = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
        chk("rst_sel_err", 32'(sel_err), 32'd0);
        rst = 1'b0;

        // Passthrough of each slice
        put(1, 2'd1, A, B, C, 1, 0);
        put(1, 2'd2, A, B, C, 1, 0);
        put(1, 2'd0, A, B, C, 1, 0);
        put(0, 2'd0, A, B, C, 1, 0);
        put(0, 2'd0, A, B, C, 1, 0);

        // Back-pressure: fill output reg and skid, hold, then drain
        put(1, 2'd0, 32'hA, B, C, 0, 0);
        put(1, 2'd0, 32'hB, B, C, 0, 0);
        put(1, 2'd0, 32'hC, B, C, 0, 0);
        put(0, 2'd0, 32'hD, B, C, 0, 0);
        put(0, 2'd0, 32'hD, B, C, 0, 0);
        put(0, 2'd0, 32'hD, B, C, 1, 0);
        put(0, 2'd0, 32'hD, B, C, 1, 0);
        put(0, 2'd0, 32'hD, B, C, 1, 0);

        // Bad select, clear alone, then clear colliding with a new bad select
        put(1, 2'd3, A, B, C, 1, 0);
        put(0, 2'd0, A, B, C, 1, 0);
        put(0, 2'd0, A, B, C, 1, 0);
        put(0, 2'd0, A, B, C, 1, 1);
        put(0, 2'd0, A, B, C, 1, 0);
        put(1, 2'd3, A, B, C, 1, 1);
        put(0, 2'd0, A, B, C, 1, 0);
        put(0, 2'd0, A, B, C, 1, 1);

        // Streaming with incrementing data
        for (int i = 0; i < 100; i++) begin
            put(1, 2'($urandom_range(0, 2)), 32'(3*i), 32'(3*i+1), 32'(3*i+2), 1, 0);
        end
        put(0, 2'd0, A, B, C, 1, 0);

        // Random traffic with random stalls, selects and clears
        for (int i = 0; i < 400; i++) begin
            put(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end

        // Async reset with skid full and sel_err set
        put(1, 2'd3, A, B, C, 0, 0);
        put(1, 2'd1, A, B, C, 0, 0);
        put(1, 2'd2, A, B, C, 0, 0);
        put(0, 2'd0, A, B, C, 0, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_sel_err", 32'(sel_err), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        put(1, 2'd2, A, B, C, 1, 0);
        put(0, 2'd0, A, B, C, 1, 0);
        put(0, 2'd0, A, B, C, 1, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
